// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner.
//
// Contents:
//   lane_state_t         per-lane debounce state
//   BTN_L..BTN_C         lane index of each board button
//   *_DEF                default timing for a 40 MHz core clock
package btn_pkg;

    // The encoding is chosen so that bit 1 is set exactly in the two
    // "button is down" states, letting the debounced level come straight
    // off a state flop.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } lane_state_t;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_U = 2;
    localparam int BTN_D = 3;
    localparam int BTN_C = 4;

    localparam int NBTN_DEF    = 5;
    localparam int DEB_CYC_DEF = 800000;    // 20 ms
    localparam int RPT_DLY_DEF = 16000000;  // 0.4 s
    localparam int RPT_PER_DEF = 4000000;   // 0.1 s
    localparam int CNTW_DEF    = 26;

endpackage

// File: rtl/btn_debounce_lane.sv
// One push-button lane: 2-flop synchroniser, debounce FSM and
// hold-to-repeat timer.
//
// Ports:
//   clk    core clock
//   rst_n  asynchronous active-low reset
//   raw    raw pad level, active-high, asynchronous to clk
//   lvl    debounced level (1 in HELD and RELEASE_WAIT)
//   dn     one-cycle pulse when a press is accepted
//   up     one-cycle pulse when a release is accepted
//   rpt    one-cycle repeat pulse while the button is held
module btn_debounce_lane
    import btn_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_DEF,
    parameter int RPT_DLY = RPT_DLY_DEF,
    parameter int RPT_PER = RPT_PER_DEF,
    parameter int CNTW    = CNTW_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic lvl,
    output logic dn,
    output logic up,
    output logic rpt
);

    localparam logic [CNTW-1:0] DEB_LAST = CNTW'(DEB_CYC - 1);
    localparam logic [CNTW-1:0] RPT_DLY_C = CNTW'(RPT_DLY);
    localparam logic [CNTW-1:0] RPT_PER_C = CNTW'(RPT_PER);
    localparam logic [CNTW-1:0] ONE = CNTW'(1);

    logic            sync_p0;
    logic            sync_p1;
    lane_state_t     state;
    lane_state_t     state_nxt;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_nxt;
    logic [CNTW-1:0] rcnt;
    logic [CNTW-1:0] rcnt_nxt;
    logic            dn_nxt;
    logic            up_nxt;
    logic            rpt_nxt;

    // Stage p0 -> p1: metastability chain; sync_p1 is the only copy of the
    // pad level that the FSM ever looks at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p1 -> state/outputs: lane FSM, counters and registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            rcnt  <= '0;
            dn    <= 1'b0;
            up    <= 1'b0;
            rpt   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rcnt  <= rcnt_nxt;
            dn    <= dn_nxt;
            up    <= up_nxt;
            rpt   <= rpt_nxt;
        end
    end

    // cnt counts consecutive cycles of the new level, so reaching
    // DEB_CYC-1 while the level still holds completes DEB_CYC cycles.
    // With DEB_CYC == 1 a single cycle suffices, so the wait states are
    // skipped entirely.
    //
    // rcnt counts down to the next repeat pulse: loaded with RPT_DLY on an
    // accepted press, reloaded with RPT_PER after each pulse. It only moves
    // while HELD sees the button down, so a rejected release glitch delays
    // the cadence by the frozen cycles instead of restarting it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rcnt_nxt  = rcnt;
        dn_nxt    = 1'b0;
        up_nxt    = 1'b0;
        rpt_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (sync_p1) begin
                    if (DEB_CYC == 1) begin
                        state_nxt = HELD;
                        dn_nxt    = 1'b1;
                        rcnt_nxt  = RPT_DLY_C;
                    end else begin
                        state_nxt = PRESS_WAIT;
                        cnt_nxt   = ONE;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!sync_p1) begin
                    state_nxt = IDLE;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = HELD;
                    dn_nxt    = 1'b1;
                    rcnt_nxt  = RPT_DLY_C;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            HELD: begin
                if (!sync_p1) begin
                    if (DEB_CYC == 1) begin
                        state_nxt = IDLE;
                        up_nxt    = 1'b1;
                    end else begin
                        state_nxt = RELEASE_WAIT;
                        cnt_nxt   = ONE;
                    end
                end else if (rcnt == ONE) begin
                    rpt_nxt  = 1'b1;
                    rcnt_nxt = RPT_PER_C;
                end else begin
                    rcnt_nxt = rcnt - ONE;
                end
            end
            RELEASE_WAIT: begin
                if (sync_p1) begin
                    state_nxt = HELD;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = IDLE;
                    up_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
        endcase
    end

    // Direct flop output: cleared immediately by the asynchronous reset.
    assign lvl = state[1];

endmodule

// File: rtl/btn_debounce_bank.sv
// Bank of independent debounced push-button lanes feeding the core.
//
// Ports:
//   clk      core clock
//   rst_n    asynchronous active-low reset
//   btn_raw  raw pad levels (bit 0=left, 1=right, 2=up, 3=down, 4=center)
//   btn_lvl  debounced levels
//   btn_dn   one-cycle press pulses
//   btn_up   one-cycle release pulses
//   btn_rpt  one-cycle hold-to-repeat pulses
module btn_debounce_bank
    import btn_pkg::*;
#(
    parameter int NBTN    = NBTN_DEF,
    parameter int DEB_CYC = DEB_CYC_DEF,
    parameter int RPT_DLY = RPT_DLY_DEF,
    parameter int RPT_PER = RPT_PER_DEF,
    parameter int CNTW    = CNTW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NBTN-1:0] btn_raw,
    output logic [NBTN-1:0] btn_lvl,
    output logic [NBTN-1:0] btn_dn,
    output logic [NBTN-1:0] btn_up,
    output logic [NBTN-1:0] btn_rpt
);

    for (genvar i = 0; i < NBTN; i++) begin : g_lane
        btn_debounce_lane #(
            .DEB_CYC(DEB_CYC),
            .RPT_DLY(RPT_DLY),
            .RPT_PER(RPT_PER),
            .CNTW   (CNTW)
        ) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btn_raw[i]),
            .lvl  (btn_lvl[i]),
            .dn   (btn_dn[i]),
            .up   (btn_up[i]),
            .rpt  (btn_rpt[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Self-checking bench for btn_debounce_bank with short timing constants.
module tb_btn_debounce_bank;
    import btn_pkg::*;

    localparam int NBTN    = 5;
    localparam int DEB_CYC = 4;
    localparam int RPT_DLY = 10;
    localparam int RPT_PER = 3;
    localparam int CNTW    = 8;
    localparam int LAT     = 2 + DEB_CYC;

    logic            clk;
    logic            rst_n;
    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] btn_lvl;
    logic [NBTN-1:0] btn_dn;
    logic [NBTN-1:0] btn_up;
    logic [NBTN-1:0] btn_rpt;

    int n_checks = 0;
    int n_fail   = 0;

    btn_debounce_bank #(
        .NBTN(NBTN), .DEB_CYC(DEB_CYC), .RPT_DLY(RPT_DLY),
        .RPT_PER(RPT_PER), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_lvl(btn_lvl), .btn_dn(btn_dn), .btn_up(btn_up), .btn_rpt(btn_rpt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per lane, the accepted level, how long the
    // synchronised input has disagreed with it, and how many cycles the
    // button has been steadily held since the accepted press.
    logic [NBTN-1:0] m_q1, m_q2;
    logic [NBTN-1:0] m_lvl, m_dn, m_up, m_rpt;
    int m_run[NBTN];
    int m_ticks[NBTN];

    function automatic bit rpt_due(int t);
        return (t == RPT_DLY) || (t > RPT_DLY && ((t - RPT_DLY) % RPT_PER) == 0);
    endfunction

    function automatic void model_clear();
        m_q1 = '0; m_q2 = '0;
        m_lvl = '0; m_dn = '0; m_up = '0; m_rpt = '0;
        for (int i = 0; i < NBTN; i++) begin
            m_run[i] = 0;
            m_ticks[i] = 0;
        end
    endfunction

    function automatic void model_edge(logic [NBTN-1:0] raw);
        logic [NBTN-1:0] s;
        s = m_q2;
        m_q2 = m_q1;
        m_q1 = raw;
        m_dn = '0; m_up = '0; m_rpt = '0;
        for (int i = 0; i < NBTN; i++) begin
            if (s[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB_CYC) begin
                    m_lvl[i] = s[i];
                    m_run[i] = 0;
                    if (s[i]) begin
                        m_dn[i] = 1'b1;
                        m_ticks[i] = 0;
                    end else begin
                        m_up[i] = 1'b1;
                    end
                end
            end else begin
                if (m_lvl[i] && m_run[i] == 0) begin
                    m_ticks[i]++;
                    if (rpt_due(m_ticks[i])) m_rpt[i] = 1'b1;
                end
                m_run[i] = 0;
            end
        end
    endfunction

    task automatic check_vec(string tag, logic [NBTN-1:0] got, logic [NBTN-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_int(string tag, int got, int exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_vec("lvl", btn_lvl, m_lvl);
        check_vec("dn",  btn_dn,  m_dn);
        check_vec("up",  btn_up,  m_up);
        check_vec("rpt", btn_rpt, m_rpt);
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_clear();
        else model_edge(btn_raw);
        #1;
        check_all();
    endtask

    task automatic ticks(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Clock until the chosen pulse appears on lane b, then check latency.
    task automatic wait_pulse(string tag, int b, bit want_up, int exp_lat);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 4 * LAT) begin
            tick();
            n++;
            seen = want_up ? btn_up[b] : btn_dn[b];
        end
        check_int(tag, n, exp_lat);
    endtask

    // Reset pulse placed between clock edges, starting 1 unit after an edge.
    task automatic async_reset_pulse(string tag);
        #3 rst_n = 1'b0;
        #1;
        model_clear();
        check_vec({tag, "_lvl"}, btn_lvl, '0);
        check_all();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_rpt;
        int first_rpt;
        int n_up;
        rst_n   = 1'b0;
        btn_raw = '1;
        model_clear();

        // Reset held with all buttons pressed.
        ticks(3);
        check_vec("rst_lvl", btn_lvl, '0);
        check_vec("rst_dn",  btn_dn,  '0);
        rst_n = 1'b1;
        wait_pulse("rst_release_dn_lat", BTN_L, 1'b0, LAT);
        check_vec("rst_release_dn_all", btn_dn, '1);
        tick();
        check_vec("rst_release_lvl_all", btn_lvl, '1);
        btn_raw = '0;
        ticks(12);

        // Clean press on the up button.
        btn_raw = 5'b00100;
        wait_pulse("clean_dn_lat", BTN_U, 1'b0, LAT);
        check_vec("clean_dn_only", btn_dn, 5'b00100);
        check_vec("clean_lvl", btn_lvl, 5'b00100);
        ticks(2);
        btn_raw = '0;
        ticks(12);

        // Bouncing press on the left button.
        btn_raw[BTN_L] = 1'b1; tick();
        btn_raw[BTN_L] = 1'b0; tick();
        btn_raw[BTN_L] = 1'b1; tick();
        btn_raw[BTN_L] = 1'b0; tick();
        btn_raw[BTN_L] = 1'b1;
        wait_pulse("bounce_dn_lat", BTN_L, 1'b0, LAT);
        btn_raw = '0;
        ticks(12);

        // Hold the centre button and watch the repeat cadence.
        btn_raw[BTN_C] = 1'b1;
        wait_pulse("hold_dn_lat", BTN_C, 1'b0, LAT);
        n_rpt = 0;
        first_rpt = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (btn_rpt[BTN_C]) begin
                n_rpt++;
                if (first_rpt < 0) first_rpt = k;
            end
        end
        check_int("rpt_first_offset", first_rpt, RPT_DLY);
        check_int("rpt_count_30", n_rpt, 7);
        btn_raw[BTN_C] = 1'b0;
        wait_pulse("hold_up_lat", BTN_C, 1'b1, LAT);
        n_rpt = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (btn_rpt[BTN_C]) n_rpt++;
        end
        check_int("rpt_after_release", n_rpt, 0);

        // Short release glitch on the right button while held.
        btn_raw[BTN_R] = 1'b1;
        wait_pulse("glitch_dn_lat", BTN_R, 1'b0, LAT);
        ticks(5);
        btn_raw[BTN_R] = 1'b0;
        ticks(2);
        btn_raw[BTN_R] = 1'b1;
        n_up = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (btn_up[BTN_R]) n_up++;
        end
        check_int("glitch_no_up", n_up, 0);
        check_vec("glitch_lvl", btn_lvl, 5'b00010);
        btn_raw = '0;
        ticks(12);

        // Asynchronous reset while the down button is held.
        btn_raw[BTN_D] = 1'b1;
        wait_pulse("areset_dn_lat", BTN_D, 1'b0, LAT);
        ticks(4);
        async_reset_pulse("areset");
        wait_pulse("areset_refire_lat", BTN_D, 1'b0, LAT);
        btn_raw = '0;
        ticks(12);

        // Random bouncing on all lanes with occasional resets.
        for (int c = 0; c < 900; c++) begin
            int idx;
            if ($urandom_range(0, 6) == 0) begin
                idx = int'($urandom_range(0, NBTN - 1));
                btn_raw[idx] = ~btn_raw[idx];
            end
            if ($urandom_range(0, 299) == 0) async_reset_pulse("rand_reset");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
